// File: rtl/uart_tx_serializer.sv
// -----------------------------------------------------------------------------
// uart_tx_serializer
//
// Data-path stage of the UART transmitter. A load (DATA_VALID while the TX FSM
// is idle) captures the parallel byte, computes the frame parity bit and latches
// the parity enable. The byte is then presented one bit per CLK while ser_en is
// high. The first ser_en cycle after a load belongs to the start bit and does
// not shift; DATA_WIDTH data cycles follow, with ser_done on the last one.
// A DATA_VALID that arrives while Busy is high raises a one-cycle ovr_err and
// leaves the frame in flight untouched.
//
// Build option:
//   UART_TX_MSB_FIRST_EN  defined   -> shift left, ser_data = MSB (MSB first)
//                         undefined -> shift right, ser_data = LSB (standard)
//
// Ports:
//   CLK         in   TX bit clock, one UART bit per cycle
//   RST         in   asynchronous reset, active low
//   P_DATA      in   parallel data, sampled only on a load
//   DATA_VALID  in   load request for P_DATA
//   Busy        in   high while the TX FSM has a frame in flight
//   ser_en      in   shift enable from the TX FSM
//   PAR_EN      in   parity enable, sampled on load
//   PAR_TYP     in   parity type (0 even, 1 odd), sampled on load
//   ser_data    out  data bit currently on the line
//   ser_done    out  last data bit is being presented
//   par_bit     out  parity bit of the captured byte (0 when parity disabled)
//   ovr_err     out  one-cycle overrun pulse
// -----------------------------------------------------------------------------
module uart_tx_serializer #(
    parameter int DATA_WIDTH = 8
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic [DATA_WIDTH-1:0] P_DATA,
    input  logic                  DATA_VALID,
    input  logic                  Busy,
    input  logic                  ser_en,
    input  logic                  PAR_EN,
    input  logic                  PAR_TYP,
    output logic                  ser_data,
    output logic                  ser_done,
    output logic                  par_bit,
    output logic                  ovr_err
);

    localparam int CNT_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(DATA_WIDTH - 1);

    logic [DATA_WIDTH-1:0] shift_reg;
    logic [DATA_WIDTH-1:0] shift_next;
    logic [CNT_W-1:0]      cnt_reg;
    logic                  start_seen_reg;
    logic                  par_calc_reg;
    logic                  par_en_reg;
    logic                  ovr_err_reg;

    logic load;
    logic done;

    assign load = DATA_VALID & ~Busy;
    assign done = ser_en & (cnt_reg == LAST_IDX);

`ifdef UART_TX_MSB_FIRST_EN
    assign shift_next = {shift_reg[DATA_WIDTH-2:0], 1'b0};
    assign ser_data   = shift_reg[DATA_WIDTH-1];
`else
    assign shift_next = {1'b0, shift_reg[DATA_WIDTH-1:1]};
    assign ser_data   = shift_reg[0];
`endif

    assign ser_done = done;
    // Parity is computed unconditionally at load; the latched enable masks it.
    assign par_bit  = par_en_reg & par_calc_reg;
    assign ovr_err  = ovr_err_reg;

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            shift_reg      <= '0;
            cnt_reg        <= '0;
            start_seen_reg <= 1'b0;
            par_calc_reg   <= 1'b0;
            par_en_reg     <= 1'b0;
            ovr_err_reg    <= 1'b0;
        end else begin
            ovr_err_reg <= DATA_VALID & Busy;

            if (load) begin
                // Load wins over a shift on the same edge.
                shift_reg      <= P_DATA;
                cnt_reg        <= '0;
                start_seen_reg <= 1'b0;
                par_en_reg     <= PAR_EN;
                par_calc_reg   <= PAR_TYP ? ~^P_DATA : ^P_DATA;
            end else if (ser_en) begin
                if (!start_seen_reg) begin
                    // Start-bit cycle: arm the shifter, keep the first bit.
                    start_seen_reg <= 1'b1;
                end else begin
                    shift_reg <= shift_next;
                    if (done) begin
                        // Wrap so a lingering ser_en never overruns the count;
                        // the next ser_en cycle is treated as a new start bit.
                        cnt_reg        <= '0;
                        start_seen_reg <= 1'b0;
                    end else begin
                        cnt_reg <= cnt_reg + 1'b1;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_uart_tx_serializer.sv
// -----------------------------------------------------------------------------
// tb_uart_tx_serializer
//
// Directed bench for uart_tx_serializer (DATA_WIDTH = 8). Expected serial
// sequences are written out by hand; bit 7 of each SEQ_* constant is the first
// data bit expected on the line. Inputs change 1 ns after the rising edge and
// outputs are sampled at the same point.
// -----------------------------------------------------------------------------
module tb_uart_tx_serializer;

    logic       CLK = 1'b0;
    logic       RST;
    logic [7:0] P_DATA;
    logic       DATA_VALID;
    logic       Busy;
    logic       ser_en;
    logic       PAR_EN;
    logic       PAR_TYP;
    logic       ser_data;
    logic       ser_done;
    logic       par_bit;
    logic       ovr_err;

    int tests_run    = 0;
    int tests_failed = 0;

`ifdef UART_TX_MSB_FIRST_EN
    localparam logic [7:0] SEQ_A5 = 8'b1010_0101;
    localparam logic [7:0] SEQ_01 = 8'b0000_0001;
    localparam logic [7:0] SEQ_80 = 8'b1000_0000;
    localparam logic [7:0] SEQ_0F = 8'b0000_1111;
`else
    localparam logic [7:0] SEQ_A5 = 8'b1010_0101;
    localparam logic [7:0] SEQ_01 = 8'b1000_0000;
    localparam logic [7:0] SEQ_80 = 8'b0000_0001;
    localparam logic [7:0] SEQ_0F = 8'b1111_0000;
`endif

    uart_tx_serializer #(.DATA_WIDTH(8)) dut (
        .CLK        (CLK),
        .RST        (RST),
        .P_DATA     (P_DATA),
        .DATA_VALID (DATA_VALID),
        .Busy       (Busy),
        .ser_en     (ser_en),
        .PAR_EN     (PAR_EN),
        .PAR_TYP    (PAR_TYP),
        .ser_data   (ser_data),
        .ser_done   (ser_done),
        .par_bit    (par_bit),
        .ovr_err    (ovr_err)
    );

    always #5 CLK = ~CLK;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic load_byte(input logic [7:0] d, input logic pe, input logic pt);
        ser_en     = 1'b0;
        P_DATA     = d;
        PAR_EN     = pe;
        PAR_TYP    = pt;
        DATA_VALID = 1'b1;
        Busy       = 1'b0;
        tick();
        DATA_VALID = 1'b0;
        Busy       = 1'b1;
    endtask

    // Start cycle plus 8 data cycles; optional overrun request at data cycle ovr_at.
    task automatic run_frame(input logic [7:0] exp_seq, input int ovr_at);
        ser_en = 1'b1;
        check_eq("start_no_done", ser_done, 1'b0);
        tick();
        for (int i = 0; i < 8; i++) begin
            check_eq("data_bit", ser_data, exp_seq[7-i]);
            check_eq("ser_done", ser_done, (i == 7) ? 1'b1 : 1'b0);
            if (i == ovr_at) begin
                DATA_VALID = 1'b1;
                P_DATA     = 8'hFF;
            end
            tick();
            if (i == ovr_at) begin
                DATA_VALID = 1'b0;
                check_eq("ovr_pulse", ovr_err, 1'b1);
            end else begin
                check_eq("ovr_idle", ovr_err, 1'b0);
            end
        end
        $display("[TB] frame sent, expected sequence %b", exp_seq);
    endtask

    initial begin
        int n;
        RST        = 1'b0;
        P_DATA     = '0;
        DATA_VALID = 1'b0;
        Busy       = 1'b0;
        ser_en     = 1'b0;
        PAR_EN     = 1'b0;
        PAR_TYP    = 1'b0;
        #12;
        check_eq("rst_ser_data", ser_data, 1'b0);
        check_eq("rst_ser_done", ser_done, 1'b0);
        check_eq("rst_par_bit", par_bit, 1'b0);
        check_eq("rst_ovr_err", ovr_err, 1'b0);
        tick();
        RST = 1'b1;
        tick();

        // 0xA5 even parity (four ones -> 0), overrun request mid-frame.
        load_byte(8'hA5, 1'b1, 1'b0);
        check_eq("par_even_a5", par_bit, 1'b0);
        run_frame(SEQ_A5, 3);

        // ser_en lingers after ser_done: counter wraps, no early ser_done.
        for (int k = 0; k < 4; k++) begin
            check_eq("wrap_no_done", ser_done, 1'b0);
            check_eq("wrap_no_x", $isunknown(ser_data), 1'b0);
            tick();
        end
        n = 0;
        while (ser_done !== 1'b1 && n < 20) begin
            tick();
            n++;
        end
        check_eq("wrap_done_cycles", n, 4);
        check_eq("wrap_ser_data", ser_data, 1'b0);
        $display("[TB] wrap run finished after %0d extra cycles", n);

        // 0xA5 odd parity; ser_en low holds the line.
        load_byte(8'hA5, 1'b1, 1'b1);
        check_eq("par_odd_a5", par_bit, 1'b1);
        tick();
        tick();
        check_eq("hold_ser_data", ser_data, 1'b1);
        run_frame(SEQ_A5, -1);
        check_eq("par_hold", par_bit, 1'b1);

        // Parity disabled masks a would-be 1.
        load_byte(8'h01, 1'b0, 1'b0);
        check_eq("par_disabled", par_bit, 1'b0);
        run_frame(SEQ_01, -1);

        load_byte(8'h80, 1'b1, 1'b0);
        check_eq("par_even_80", par_bit, 1'b1);
        run_frame(SEQ_80, -1);

        // Reset in the middle of a frame, while a 1 is on the line.
        load_byte(8'hA5, 1'b1, 1'b1);
        ser_en = 1'b1;
        for (int k = 0; k < 6; k++) tick();
        check_eq("pre_rst_ser_data", ser_data, 1'b1);
        #2;
        RST = 1'b0;
        #1;
        check_eq("midrst_ser_data", ser_data, 1'b0);
        check_eq("midrst_ser_done", ser_done, 1'b0);
        check_eq("midrst_par_bit", par_bit, 1'b0);
        tick();
        ser_en = 1'b0;
        tick();
        RST = 1'b1;
        tick();
        load_byte(8'h0F, 1'b1, 1'b0);
        check_eq("par_even_0f", par_bit, 1'b0);
        run_frame(SEQ_0F, -1);

        ser_en = 1'b0;
        Busy   = 1'b0;
        tick();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

endmodule
